// File: rtl/timer_pkg.sv
// -----------------------------------------------------------------------------
// timer_pkg
//
// Shared types and constants for the mode_timer channel and for the blocks
// that reuse its prescaler (PWM bases, watchdogs).
//
// Contents:
//   mode_e              - counting mode of a timer channel
//   TIMER_WIDTH_DEF     - default counter width
//   TIMER_PS_WIDTH_DEF  - default prescaler width
//   is_terminal()       - true when a count sits on the wrap boundary of
//                         its direction (all ones going up, zero going down)
// -----------------------------------------------------------------------------
package timer_pkg;

    // MODE_RSVD is decoded exactly like MODE_UP so that a stray write of the
    // reserved encoding still leaves a running, well-defined timer.
    typedef enum logic [1:0] {
        MODE_UP      = 2'd0,
        MODE_DOWN    = 2'd1,
        MODE_ONESHOT = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    localparam int TIMER_WIDTH_DEF    = 16;
    localparam int TIMER_PS_WIDTH_DEF = 8;

    // Wrap boundary test, shared so that every timer-style block agrees on
    // where UP and DOWN counts turn over. Anything other than DOWN counts up.
    function automatic logic is_terminal(
        input logic [31:0] cnt,
        input int unsigned width,
        input mode_e       mode
    );
        logic [31:0] all_ones;
        all_ones = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        if (mode == MODE_DOWN) begin
            return (cnt & all_ones) == 32'd0;
        end
        return (cnt & all_ones) == all_ones;
    endfunction

endpackage

// File: rtl/mode_timer_if.sv
// -----------------------------------------------------------------------------
// mode_timer_if
//
// Control and status bundle of one mode_timer channel. clk and rst are kept
// out of the interface and travel as plain module ports.
//
// Signals:
//   en_i          run enable
//   mode_i        counting mode (mode_e)
//   prescale_i    counter steps once every prescale_i+1 enabled cycles
//   load_i        synchronous load strobe
//   load_val_i    value written on load_i
//   reload_val_i  value taken on an UP/DOWN wrap
//   cmp_i         compare value
//   irq_clr_i     clears the sticky interrupt
//   cnt_o         current count
//   match_o       one-cycle pulse, a step reached cmp_i
//   wrap_o        one-cycle pulse, count wrapped and was reloaded
//   done_o        level, ONESHOT run has reached cmp_i
//   irq_o         sticky interrupt, set by match_o or wrap_o
//
// Modports:
//   master - the controller side (drives the *_i signals)
//   slave  - the timer side (drives the *_o signals)
// -----------------------------------------------------------------------------
interface mode_timer_if
    import timer_pkg::*;
#(
    parameter int WIDTH    = TIMER_WIDTH_DEF,
    parameter int PS_WIDTH = TIMER_PS_WIDTH_DEF
);

    logic                en_i;
    mode_e               mode_i;
    logic [PS_WIDTH-1:0] prescale_i;
    logic                load_i;
    logic [WIDTH-1:0]    load_val_i;
    logic [WIDTH-1:0]    reload_val_i;
    logic [WIDTH-1:0]    cmp_i;
    logic                irq_clr_i;

    logic [WIDTH-1:0]    cnt_o;
    logic                match_o;
    logic                wrap_o;
    logic                done_o;
    logic                irq_o;

    modport master (
        output en_i,
        output mode_i,
        output prescale_i,
        output load_i,
        output load_val_i,
        output reload_val_i,
        output cmp_i,
        output irq_clr_i,
        input  cnt_o,
        input  match_o,
        input  wrap_o,
        input  done_o,
        input  irq_o
    );

    modport slave (
        input  en_i,
        input  mode_i,
        input  prescale_i,
        input  load_i,
        input  load_val_i,
        input  reload_val_i,
        input  cmp_i,
        input  irq_clr_i,
        output cnt_o,
        output match_o,
        output wrap_o,
        output done_o,
        output irq_o
    );

endinterface

// File: rtl/timer_prescaler.sv
// -----------------------------------------------------------------------------
// timer_prescaler
//
// Divides the enabled clock cycles by prescale_i+1 and emits a single-cycle
// step strobe at the end of each period. Reused by the PWM and watchdog
// blocks, so it knows nothing about counting modes.
//
// Ports:
//   clk         clock
//   rst         synchronous reset, active-high (phase returns to 0)
//   en_i        advance enable; phase holds while low
//   clr_i       restart the phase at 0 (wins over en_i)
//   prescale_i  period minus one
//   step_o      combinational strobe, high on the last cycle of a period
// -----------------------------------------------------------------------------
module timer_prescaler
    import timer_pkg::*;
#(
    parameter int PS_WIDTH = TIMER_PS_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_i,
    input  logic                clr_i,
    input  logic [PS_WIDTH-1:0] prescale_i,
    output logic                step_o
);

    logic [PS_WIDTH-1:0] ps_reg;
    logic [PS_WIDTH-1:0] ps_next;

    // >= rather than ==: if prescale_i is lowered below the running phase,
    // the very next enabled cycle ends the period instead of the phase
    // running all the way round the register first.
    assign step_o = en_i && (ps_reg >= prescale_i);

    always_comb begin
        ps_next = ps_reg;
        if (clr_i) begin
            ps_next = '0;
        end else if (step_o) begin
            ps_next = '0;
        end else if (en_i) begin
            ps_next = ps_reg + PS_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_reg <= '0;
        end else begin
            ps_reg <= ps_next;
        end
    end

endmodule

// File: rtl/mode_timer.sv
// -----------------------------------------------------------------------------
// mode_timer
//
// One channel of a prescaled timer/counter. Counts up, counts down or runs
// a one-shot to a compare value, reloading on wrap in the free-running
// modes, with registered match/wrap pulses and a sticky interrupt flag.
// Multi-channel timers instantiate this block once per channel.
//
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high; clears count, phase and all flags
//   tif  mode_timer_if.slave - controls in, count and status out
//
// Per-cycle priority: rst > load > step > hold. Every output is a register,
// so inputs show up on cnt_o and the flags one cycle later.
// -----------------------------------------------------------------------------
module mode_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = TIMER_WIDTH_DEF,
    parameter int PS_WIDTH = TIMER_PS_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mode_timer_if.slave  tif
);

    logic             step;

    logic [WIDTH-1:0] cnt_reg;
    logic [WIDTH-1:0] cnt_next;
    logic             done_reg;
    logic             done_next;
    logic             match_reg;
    logic             match_next;
    logic             wrap_reg;
    logic             wrap_next;
    logic             irq_reg;
    logic             irq_next;

    // Set when this cycle's step really moves the count. A ONESHOT step that
    // arrives after done is swallowed and must not re-fire match.
    logic             advance;
    logic             at_terminal;

    // -------------------------------------------------------------------------
    // Prescaler: load restarts the phase so a freshly loaded value is held
    // for a full period before the first step.
    // -------------------------------------------------------------------------
    timer_prescaler #(
        .PS_WIDTH (PS_WIDTH)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .en_i       (tif.en_i),
        .clr_i      (tif.load_i),
        .prescale_i (tif.prescale_i),
        .step_o     (step)
    );

    assign at_terminal = is_terminal(32'(cnt_reg), WIDTH, tif.mode_i);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cnt_next  = cnt_reg;
        done_next = done_reg;
        wrap_next = 1'b0;
        advance   = 1'b0;

        if (tif.load_i) begin
            // Load is silent: no match or wrap, and it re-arms ONESHOT.
            cnt_next  = tif.load_val_i;
            done_next = 1'b0;
        end else if (step) begin
            case (tif.mode_i)
                MODE_DOWN: begin
                    advance = 1'b1;
                    if (at_terminal) begin
                        cnt_next  = tif.reload_val_i;
                        wrap_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg - WIDTH'(1);
                    end
                end

                MODE_ONESHOT: begin
                    // Increments until the count arrives at cmp_i. Starting
                    // on cmp_i is not "arrived": the run goes all the way
                    // round the register first. Rolling over here is plain
                    // modulo arithmetic with no reload and no wrap pulse.
                    if (!done_reg) begin
                        advance  = 1'b1;
                        cnt_next = cnt_reg + WIDTH'(1);
                        if (cnt_next == tif.cmp_i) begin
                            done_next = 1'b1;
                        end
                    end
                end

                default: begin
                    // MODE_UP and the reserved encoding.
                    advance = 1'b1;
                    if (at_terminal) begin
                        cnt_next  = tif.reload_val_i;
                        wrap_next = 1'b1;
                    end else begin
                        cnt_next = cnt_reg + WIDTH'(1);
                    end
                end
            endcase
        end

        // A reload that lands on cmp_i counts as a match, so match and wrap
        // can pulse together.
        match_next = advance && (cnt_next == tif.cmp_i);

        // A new event wins over a clear arriving in the same cycle.
        irq_next = (irq_reg && !tif.irq_clr_i) || match_next || wrap_next;
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg   <= '0;
            done_reg  <= 1'b0;
            match_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            irq_reg   <= 1'b0;
        end else begin
            cnt_reg   <= cnt_next;
            done_reg  <= done_next;
            match_reg <= match_next;
            wrap_reg  <= wrap_next;
            irq_reg   <= irq_next;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign tif.cnt_o   = cnt_reg;
    assign tif.match_o = match_reg;
    assign tif.wrap_o  = wrap_reg;
    assign tif.done_o  = done_reg;
    assign tif.irq_o   = irq_reg;

endmodule

// File: tb/tb_mode_timer.sv
// -----------------------------------------------------------------------------
// tb_mode_timer
//
// Self-checking bench for one mode_timer channel (WIDTH=16, PS_WIDTH=8).
// Each scenario task builds a table of per-cycle stimulus rows, each row
// carrying the outputs expected right after that cycle's clock edge. When a
// row is driven its expectation is pushed to a scoreboard queue; after the
// edge it is popped and compared with what the DUT shows.
// -----------------------------------------------------------------------------
module tb_mode_timer;
    import timer_pkg::*;

    typedef struct packed {
        logic [15:0] cnt;
        logic        match;
        logic        wrap;
        logic        done;
        logic        irq;
    } obs_t;

    typedef struct {
        bit          en;
        bit          load;
        logic [15:0] load_val;
        bit          clr;
        bit          rst;
        logic [7:0]  ps;
        obs_t        exp;
    } row_t;

    logic clk = 1'b0;
    logic rst;

    int compared   = 0;
    int mismatched = 0;

    row_t rows[$];
    obs_t exp_q[$];

    mode_timer_if #(.WIDTH(16), .PS_WIDTH(8)) tif ();

    mode_timer #(.WIDTH(16), .PS_WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, summary not yet printed");
        $fatal(1, "time limit");
    end

    function automatic row_t r(bit en, bit ld, logic [15:0] v, bit clr, bit rs,
                               logic [7:0] ps, logic [15:0] c,
                               logic m, logic w, logic d, logic i);
        row_t x;
        x.en = en; x.load = ld; x.load_val = v; x.clr = clr; x.rst = rs; x.ps = ps;
        x.exp = '{cnt: c, match: m, wrap: w, done: d, irq: i};
        return x;
    endfunction

    function automatic obs_t observe();
        return '{cnt: tif.cnt_o, match: tif.match_o, wrap: tif.wrap_o,
                 done: tif.done_o, irq: tif.irq_o};
    endfunction

    // Drive one row's stimulus and book its expectation.
    task automatic apply(input row_t x);
        tif.en_i       = x.en;
        tif.load_i     = x.load;
        tif.load_val_i = x.load_val;
        tif.irq_clr_i  = x.clr;
        tif.prescale_i = x.ps;
        rst            = x.rst;
        exp_q.push_back(x.exp);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        obs_t e, g;
        rows.push_back(r(0, 0, 16'h0, 0, 1, 0, 16'h0000, 0, 0, 0, 0));
        rows.push_back(r(1, 1, 16'h9, 1, 1, 0, 16'h0000, 0, 0, 0, 0));
        rows.push_back(r(0, 0, 16'h0, 0, 0, 0, 16'h0000, 0, 0, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = exp_q.pop_front(); g = observe(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL reset[%0d] got cnt=%h m=%b w=%b d=%b i=%b required cnt=%h m=%b w=%b d=%b i=%b",
                         k, g.cnt, g.match, g.wrap, g.done, g.irq, e.cnt, e.match, e.wrap, e.done, e.irq);
            end else $display("reset[%0d] ok cnt=%h m=%b w=%b d=%b i=%b", k, g.cnt, g.match, g.wrap, g.done, g.irq);
        end
        rows.delete();
    endtask

    task automatic test_up();
        obs_t e, g;
        tif.mode_i = MODE_UP; tif.reload_val_i = 16'h0005; tif.cmp_i = 16'hFFFF;
        rows.push_back(r(1, 1, 16'hFFFD, 0, 0, 0, 16'hFFFD, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'hFFFE, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'hFFFF, 1, 0, 0, 1));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h0005, 0, 1, 0, 1));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h0006, 0, 0, 0, 1));
        rows.push_back(r(1, 0, 16'h0,    1, 0, 0, 16'h0007, 0, 0, 0, 0));
        rows.push_back(r(0, 0, 16'h0,    0, 0, 0, 16'h0007, 0, 0, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = exp_q.pop_front(); g = observe(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL up[%0d] got cnt=%h m=%b w=%b d=%b i=%b required cnt=%h m=%b w=%b d=%b i=%b",
                         k, g.cnt, g.match, g.wrap, g.done, g.irq, e.cnt, e.match, e.wrap, e.done, e.irq);
            end else $display("up[%0d] ok cnt=%h m=%b w=%b d=%b i=%b", k, g.cnt, g.match, g.wrap, g.done, g.irq);
        end
        rows.delete();
    endtask

    // Step every 3rd enabled cycle; a 5-cycle en_i gap must freeze count and phase.
    task automatic test_down();
        obs_t e, g;
        tif.mode_i = MODE_DOWN; tif.reload_val_i = 16'd10; tif.cmp_i = 16'h0100;
        rows.push_back(r(1, 1, 16'd3, 0, 0, 2, 16'd3, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd3, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd3, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd2, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd2, 0, 0, 0, 0));
        for (int n = 0; n < 5; n++)
            rows.push_back(r(0, 0, 16'd0, 0, 0, 2, 16'd2, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd2, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd1, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd1, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd1, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd0, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd0, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd0, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd10, 0, 1, 0, 1));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 2, 16'd10, 0, 0, 0, 1));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = exp_q.pop_front(); g = observe(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL down[%0d] got cnt=%h m=%b w=%b d=%b i=%b required cnt=%h m=%b w=%b d=%b i=%b",
                         k, g.cnt, g.match, g.wrap, g.done, g.irq, e.cnt, e.match, e.wrap, e.done, e.irq);
            end else $display("down[%0d] ok cnt=%h m=%b w=%b d=%b i=%b", k, g.cnt, g.match, g.wrap, g.done, g.irq);
        end
        rows.delete();
    endtask

    task automatic test_oneshot();
        obs_t e, g;
        tif.mode_i = MODE_ONESHOT; tif.reload_val_i = 16'h0; tif.cmp_i = 16'd4;
        rows.push_back(r(1, 1, 16'd0, 1, 0, 0, 16'd0, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 0, 16'd1, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 0, 16'd2, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 0, 16'd3, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 0, 16'd4, 1, 0, 1, 1));
        for (int n = 0; n < 3; n++)
            rows.push_back(r(1, 0, 16'd0, 0, 0, 0, 16'd4, 0, 0, 1, 1));
        rows.push_back(r(1, 1, 16'd0, 0, 0, 0, 16'd0, 0, 0, 0, 1));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 0, 16'd1, 0, 0, 0, 1));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 0, 16'd2, 0, 0, 0, 1));
        // Loaded with the compare value: not done, keeps counting past it.
        rows.push_back(r(1, 1, 16'd4, 1, 0, 0, 16'd4, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 0, 16'd5, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 0, 16'd6, 0, 0, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = exp_q.pop_front(); g = observe(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL oneshot[%0d] got cnt=%h m=%b w=%b d=%b i=%b required cnt=%h m=%b w=%b d=%b i=%b",
                         k, g.cnt, g.match, g.wrap, g.done, g.irq, e.cnt, e.match, e.wrap, e.done, e.irq);
            end else $display("oneshot[%0d] ok cnt=%h m=%b w=%b d=%b i=%b", k, g.cnt, g.match, g.wrap, g.done, g.irq);
        end
        rows.delete();
    endtask

    // Load vs step priority, phase restart on load, prescale lowered mid-period.
    task automatic test_load_step();
        obs_t e, g;
        tif.mode_i = MODE_UP; tif.reload_val_i = 16'h0; tif.cmp_i = 16'd7;
        rows.push_back(r(0, 1, 16'd0, 1, 0, 1, 16'd0, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 1, 16'd0, 0, 0, 0, 0));
        rows.push_back(r(1, 1, 16'd7, 0, 0, 1, 16'd7, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 1, 16'd7, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 1, 16'd8, 0, 0, 0, 0));
        rows.push_back(r(1, 1, 16'd7, 0, 0, 1, 16'd7, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 1, 16'd7, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 1, 16'd8, 0, 0, 0, 0));
        rows.push_back(r(1, 1, 16'h40, 0, 0, 5, 16'h40, 0, 0, 0, 0));
        for (int n = 0; n < 3; n++)
            rows.push_back(r(1, 0, 16'd0, 0, 0, 5, 16'h40, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 1, 16'h41, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 1, 16'h41, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'd0, 0, 0, 1, 16'h42, 0, 0, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = exp_q.pop_front(); g = observe(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL load_step[%0d] got cnt=%h m=%b w=%b d=%b i=%b required cnt=%h m=%b w=%b d=%b i=%b",
                         k, g.cnt, g.match, g.wrap, g.done, g.irq, e.cnt, e.match, e.wrap, e.done, e.irq);
            end else $display("load_step[%0d] ok cnt=%h m=%b w=%b d=%b i=%b", k, g.cnt, g.match, g.wrap, g.done, g.irq);
        end
        rows.delete();
    endtask

    task automatic test_irq_clr();
        obs_t e, g;
        tif.mode_i = MODE_UP; tif.reload_val_i = 16'h0020; tif.cmp_i = 16'h0100;
        rows.push_back(r(1, 1, 16'hFFFE, 1, 0, 0, 16'hFFFE, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'hFFFF, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    1, 0, 0, 16'h0020, 0, 1, 0, 1));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h0021, 0, 0, 0, 1));
        rows.push_back(r(1, 0, 16'h0,    1, 0, 0, 16'h0022, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h0023, 0, 0, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = exp_q.pop_front(); g = observe(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL irq_clr[%0d] got cnt=%h m=%b w=%b d=%b i=%b required cnt=%h m=%b w=%b d=%b i=%b",
                         k, g.cnt, g.match, g.wrap, g.done, g.irq, e.cnt, e.match, e.wrap, e.done, e.irq);
            end else $display("irq_clr[%0d] ok cnt=%h m=%b w=%b d=%b i=%b", k, g.cnt, g.match, g.wrap, g.done, g.irq);
        end
        rows.delete();
        // Reload value equal to the compare value: match and wrap together.
        tif.cmp_i = 16'h0020;
        rows.push_back(r(1, 1, 16'hFFFF, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h0020, 1, 1, 0, 1));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h0021, 0, 0, 0, 1));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = exp_q.pop_front(); g = observe(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL match_wrap[%0d] got cnt=%h m=%b w=%b d=%b i=%b required cnt=%h m=%b w=%b d=%b i=%b",
                         k, g.cnt, g.match, g.wrap, g.done, g.irq, e.cnt, e.match, e.wrap, e.done, e.irq);
            end else $display("match_wrap[%0d] ok cnt=%h m=%b w=%b d=%b i=%b", k, g.cnt, g.match, g.wrap, g.done, g.irq);
        end
        rows.delete();
    endtask

    task automatic test_reset_mid();
        obs_t e, g;
        tif.mode_i = MODE_ONESHOT; tif.reload_val_i = 16'h0; tif.cmp_i = 16'h1234;
        rows.push_back(r(1, 1, 16'h1232, 1, 0, 0, 16'h1232, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h1233, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h1234, 1, 0, 1, 1));
        rows.push_back(r(1, 1, 16'h0055, 0, 1, 0, 16'h0000, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h0001, 0, 0, 0, 0));
        rows.push_back(r(1, 0, 16'h0,    0, 0, 0, 16'h0002, 0, 0, 0, 0));
        foreach (rows[k]) begin
            apply(rows[k]);
            e = exp_q.pop_front(); g = observe(); compared++;
            if (g !== e) begin
                mismatched++;
                $display("FAIL reset_mid[%0d] got cnt=%h m=%b w=%b d=%b i=%b required cnt=%h m=%b w=%b d=%b i=%b",
                         k, g.cnt, g.match, g.wrap, g.done, g.irq, e.cnt, e.match, e.wrap, e.done, e.irq);
            end else $display("reset_mid[%0d] ok cnt=%h m=%b w=%b d=%b i=%b", k, g.cnt, g.match, g.wrap, g.done, g.irq);
        end
        rows.delete();
    endtask

    initial begin
        rst              = 1'b1;
        tif.en_i         = 1'b0;
        tif.mode_i       = MODE_UP;
        tif.prescale_i   = '0;
        tif.load_i       = 1'b0;
        tif.load_val_i   = '0;
        tif.reload_val_i = '0;
        tif.cmp_i        = '0;
        tif.irq_clr_i    = 1'b0;
        @(posedge clk);
        #1;

        test_reset();
        test_up();
        test_down();
        test_oneshot();
        test_load_step();
        test_irq_clr();
        test_reset_mid();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
